// File: rtl/sp_ram_param_if.sv
// Signal bundle for sp_ram_param: clear control plus the single user access port.
interface sp_ram_param_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 12
) ();
    logic              clr;
    logic              busy;
    logic              ce;
    logic              oce;
    logic              wre;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              rd_valid;

    modport master (
        output clr, ce, oce, wre, ad, din,
        input  busy, dout, rd_valid
    );

    modport slave (
        input  clr, ce, oce, wre, ad, din,
        output busy, dout, rd_valid
    );
endinterface

// File: rtl/sp_ram_param.sv
// Parametrised single-port RAM with selectable read/write modes and a
// sweep engine that fills every word with CLR_VALUE while locking out users.
module sp_ram_param #(
    parameter int unsigned        DATA_W     = 16,
    parameter int unsigned        ADDR_W     = 12,
    parameter int unsigned        READ_MODE  = 0,
    parameter int unsigned        WRITE_MODE = 0,
    parameter logic [DATA_W-1:0]  CLR_VALUE  = '0
) (
    input logic           clk,
    input logic           reset,
    sp_ram_param_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic              busy_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] stage1;
    logic              stage1_valid;
    logic [DATA_W-1:0] dout_q;
    logic              rd_valid_q;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              rd_acc;
    logic              wr_acc;
    logic              sweep;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic; the sweep ends after writing the last address
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.clr) state_nxt = CLEAR;
            CLEAR:   if (&cnt)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Array port steering; clr beats a same-cycle user access, reset blocks all writes
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = bus.ad;
        mem_wdata = bus.din;
        rd_acc    = 1'b0;
        wr_acc    = 1'b0;
        sweep     = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.clr && bus.ce) begin
                    wr_acc = bus.wre;
                    rd_acc = !bus.wre;
                    mem_we = bus.wre;
                end
            end
            CLEAR: begin
                sweep     = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = cnt;
                mem_wdata = CLR_VALUE;
            end
            default: ;
        endcase
        if (reset) begin
            mem_we = 1'b0;
            rd_acc = 1'b0;
            wr_acc = 1'b0;
            sweep  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            busy_q <= 1'b0;
        end else begin
            busy_q <= (state_nxt == CLEAR);
            cnt    <= sweep ? cnt + ADDR_W'(1) : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // First output stage; frozen during a sweep
    always_ff @(posedge clk) begin
        if (reset) begin
            stage1       <= '0;
            stage1_valid <= 1'b0;
        end else if (state == IDLE) begin
            stage1_valid <= rd_acc;
            if (rd_acc || (wr_acc && WRITE_MODE == 2)) stage1 <= mem[bus.ad];
            else if (wr_acc && WRITE_MODE == 1)         stage1 <= bus.din;
        end
    end

    generate
        if (READ_MODE == 0) begin : g_bypass
            assign dout_q     = stage1;
            assign rd_valid_q = stage1_valid;
        end else begin : g_pipe
            // Second output register, advanced only on oce while idle
            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q     <= '0;
                    rd_valid_q <= 1'b0;
                end else if (state == IDLE) begin
                    rd_valid_q <= bus.oce & stage1_valid;
                    if (bus.oce) dout_q <= stage1;
                end else begin
                    rd_valid_q <= 1'b0;
                end
            end
        end
    endgenerate

    assign bus.dout     = dout_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_sp_ram_param.sv
// Directed and scoreboard bench for sp_ram_param across several parameter sets.
module tb_sp_ram_param;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    sp_ram_param_if #(.DATA_W(16), .ADDR_W(12)) if0 ();
    sp_ram_param_if #(.DATA_W(16), .ADDR_W(12)) if1 ();
    sp_ram_param_if #(.DATA_W(16), .ADDR_W(12)) if2 ();
    sp_ram_param_if #(.DATA_W(16), .ADDR_W(12)) if3 ();
    sp_ram_param_if #(.DATA_W(16), .ADDR_W(4))  ifc ();
    sp_ram_param_if #(.DATA_W(8),  .ADDR_W(6))  ifr ();

    sp_ram_param #(.DATA_W(16), .ADDR_W(12), .READ_MODE(0), .WRITE_MODE(0))
        u0 (.clk(clk), .reset(reset), .bus(if0));
    sp_ram_param #(.DATA_W(16), .ADDR_W(12), .READ_MODE(1), .WRITE_MODE(0))
        u1 (.clk(clk), .reset(reset), .bus(if1));
    sp_ram_param #(.DATA_W(16), .ADDR_W(12), .READ_MODE(0), .WRITE_MODE(1))
        u2 (.clk(clk), .reset(reset), .bus(if2));
    sp_ram_param #(.DATA_W(16), .ADDR_W(12), .READ_MODE(0), .WRITE_MODE(2))
        u3 (.clk(clk), .reset(reset), .bus(if3));
    sp_ram_param #(.DATA_W(16), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE(0), .CLR_VALUE(16'h7FFF))
        uc (.clk(clk), .reset(reset), .bus(ifc));
    sp_ram_param #(.DATA_W(8), .ADDR_W(6), .READ_MODE(0), .WRITE_MODE(0))
        ur (.clk(clk), .reset(reset), .bus(ifr));

    // Write-mode instances follow the stimulus applied to u0
    assign if2.clr = if0.clr;  assign if3.clr = if0.clr;
    assign if2.ce  = if0.ce;   assign if3.ce  = if0.ce;
    assign if2.oce = if0.oce;  assign if3.oce = if0.oce;
    assign if2.wre = if0.wre;  assign if3.wre = if0.wre;
    assign if2.ad  = if0.ad;   assign if3.ad  = if0.ad;
    assign if2.din = if0.din;  assign if3.din = if0.din;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vectors += 6;
        if (if0.dout !== 16'h0 || if0.rd_valid !== 1'b0 || if0.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_u0: dout=%h rv=%b busy=%b, want 0000 0 0", if0.dout, if0.rd_valid, if0.busy);
        end
        if (if1.dout !== 16'h0 || if1.rd_valid !== 1'b0 || if1.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_u1: dout=%h rv=%b busy=%b, want 0000 0 0", if1.dout, if1.rd_valid, if1.busy);
        end
        if (if2.dout !== 16'h0 || if3.dout !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_u2u3: dout=%h/%h, want 0000", if2.dout, if3.dout);
        end
        if (ifc.dout !== 16'h0 || ifc.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_uc: dout=%h busy=%b, want 0000 0", ifc.dout, ifc.busy);
        end
        if (ifr.dout !== 8'h0 || ifr.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ur: dout=%h rv=%b, want 00 0", ifr.dout, ifr.rd_valid);
        end
        if (ifr.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ur_busy: busy=%b, want 0", ifr.busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_bypass();
        if0.ce = 1'b1; if0.wre = 1'b1; if0.ad = 12'h005; if0.din = 16'h1234;
        tick();
        if0.ad = 12'hFFF; if0.din = 16'hBEEF;
        tick();
        if0.wre = 1'b0; if0.ad = 12'h005;
        tick();
        vectors++;
        if (if0.dout !== 16'h1234 || if0.rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass_rd0: dout=%h rv=%b, want 1234 1", if0.dout, if0.rd_valid);
        end
        if0.ad = 12'hFFF;
        tick();
        vectors++;
        if (if0.dout !== 16'hBEEF || if0.rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bypass_rd1: dout=%h rv=%b, want beef 1", if0.dout, if0.rd_valid);
        end
        if0.wre = 1'b1; if0.ad = 12'h100; if0.din = 16'h0ABC;
        tick();
        vectors++;
        if (if0.dout !== 16'hBEEF || if0.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_wr_hold: dout=%h rv=%b, want beef 0", if0.dout, if0.rd_valid);
        end
        if0.wre = 1'b0;
        tick();
        vectors++;
        if (if0.dout !== 16'h0ABC || if0.rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_then_rd: dout=%h rv=%b, want 0abc 1", if0.dout, if0.rd_valid);
        end
        if0.ce = 1'b0;
        tick();
        vectors++;
        if (if0.dout !== 16'h0ABC || if0.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_idle: dout=%h rv=%b, want 0abc 0", if0.dout, if0.rd_valid);
        end
    endtask

    task automatic test_pipeline();
        if1.ce = 1'b1; if1.wre = 1'b1; if1.oce = 1'b0; if1.ad = 12'h005; if1.din = 16'h1234;
        tick();
        if1.ad = 12'h007; if1.din = 16'h4321;
        tick();
        if1.wre = 1'b0; if1.ad = 12'h005; if1.oce = 1'b1;
        tick();
        vectors++;
        if (if1.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pipe_n1: rv=%b, want 0", if1.rd_valid);
        end
        if1.ce = 1'b0;
        tick();
        vectors++;
        if (if1.dout !== 16'h1234 || if1.rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pipe_n2: dout=%h rv=%b, want 1234 1", if1.dout, if1.rd_valid);
        end
        tick();
        vectors++;
        if (if1.dout !== 16'h1234 || if1.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pipe_n3: dout=%h rv=%b, want 1234 0", if1.dout, if1.rd_valid);
        end
        if1.ce = 1'b1; if1.ad = 12'h007; if1.oce = 1'b0;
        tick();
        if1.ce = 1'b0;
        tick();
        vectors++;
        if (if1.dout !== 16'h1234 || if1.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pipe_oce_low: dout=%h rv=%b, want 1234 0", if1.dout, if1.rd_valid);
        end
        // back-to-back reads with oce held high
        if1.ce = 1'b1; if1.ad = 12'h005; if1.oce = 1'b1;
        tick();
        vectors++;
        if (if1.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pipe_b2b_0: rv=%b, want 0", if1.rd_valid);
        end
        if1.ad = 12'h007;
        tick();
        vectors++;
        if (if1.dout !== 16'h1234 || if1.rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pipe_b2b_1: dout=%h rv=%b, want 1234 1", if1.dout, if1.rd_valid);
        end
        if1.ce = 1'b0;
        tick();
        vectors++;
        if (if1.dout !== 16'h4321 || if1.rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pipe_b2b_2: dout=%h rv=%b, want 4321 1", if1.dout, if1.rd_valid);
        end
        if1.oce = 1'b0;
        tick();
    endtask

    task automatic test_write_modes();
        if0.ce = 1'b1; if0.wre = 1'b1; if0.ad = 12'h010; if0.din = 16'h00AA;
        tick();
        if0.ad = 12'h020; if0.din = 16'h3C3C;
        tick();
        if0.wre = 1'b0;
        tick();
        vectors++;
        if (if0.dout !== 16'h3C3C || if2.dout !== 16'h3C3C || if3.dout !== 16'h3C3C) begin
            miscompares++;
            $display("FAIL wm_preread: dout=%h/%h/%h, want 3c3c", if0.dout, if2.dout, if3.dout);
        end
        if0.wre = 1'b1; if0.ad = 12'h010; if0.din = 16'h0055;
        tick();
        vectors += 4;
        if (if0.dout !== 16'h3C3C) begin
            miscompares++;
            $display("FAIL wm0_normal: dout=%h, want 3c3c", if0.dout);
        end
        if (if2.dout !== 16'h0055) begin
            miscompares++;
            $display("FAIL wm1_through: dout=%h, want 0055", if2.dout);
        end
        if (if3.dout !== 16'h00AA) begin
            miscompares++;
            $display("FAIL wm2_rbw: dout=%h, want 00aa", if3.dout);
        end
        if (if0.rd_valid !== 1'b0 || if2.rd_valid !== 1'b0 || if3.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wm_rv: rv=%b%b%b, want 000", if0.rd_valid, if2.rd_valid, if3.rd_valid);
        end
        if0.wre = 1'b0;
        tick();
        vectors++;
        if (if0.dout !== 16'h0055 || if2.dout !== 16'h0055 || if3.dout !== 16'h0055) begin
            miscompares++;
            $display("FAIL wm_reread: dout=%h/%h/%h, want 0055", if0.dout, if2.dout, if3.dout);
        end
        if0.ce = 1'b0;
        tick();
    endtask

    task automatic test_clear();
        int busy_cycles;
        for (int i = 0; i < 16; i++) begin
            ifc.ce = 1'b1; ifc.wre = 1'b1; ifc.ad = 4'(i); ifc.din = 16'(16'h1000 + i);
            tick();
        end
        ifc.wre = 1'b0; ifc.ad = 4'd2;
        tick();
        vectors++;
        if (ifc.dout !== 16'h1002 || ifc.rd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_preload: dout=%h rv=%b, want 1002 1", ifc.dout, ifc.rd_valid);
        end
        ifc.clr = 1'b1; ifc.wre = 1'b1; ifc.ad = 4'd3; ifc.din = 16'hDEAD;
        tick();
        ifc.clr = 1'b0; ifc.ad = 4'd0; ifc.din = 16'h0BAD;
        busy_cycles = (ifc.busy === 1'b1) ? 1 : 0;
        for (int k = 0; k < 40 && ifc.busy === 1'b1; k++) begin
            vectors++;
            if (ifc.dout !== 16'h1002 || ifc.rd_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL clr_lockout: dout=%h rv=%b, want 1002 0", ifc.dout, ifc.rd_valid);
            end
            ifc.wre = k[0];
            tick();
            if (ifc.busy === 1'b1) busy_cycles++;
        end
        ifc.ce = 1'b0;
        vectors++;
        if (busy_cycles !== 16 || ifc.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_busy_len: cycles=%0d busy=%b, want 16 0", busy_cycles, ifc.busy);
        end
        for (int i = 0; i < 16; i++) begin
            ifc.ce = 1'b1; ifc.wre = 1'b0; ifc.ad = 4'(i);
            tick();
            vectors++;
            if (ifc.dout !== 16'h7FFF || ifc.rd_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL clr_read[%0d]: dout=%h rv=%b, want 7fff 1", i, ifc.dout, ifc.rd_valid);
            end
        end
        ifc.ce = 1'b0;
        tick();
    endtask

    task automatic test_clear_abort();
        logic [15:0] exp;
        for (int i = 0; i < 16; i++) begin
            ifc.ce = 1'b1; ifc.wre = 1'b1; ifc.ad = 4'(i); ifc.din = 16'(16'h2000 + i);
            tick();
        end
        ifc.ce = 1'b0; ifc.clr = 1'b1;
        tick();
        ifc.clr = 1'b0;
        repeat (5) tick();
        vectors++;
        if (ifc.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_busy_pre: busy=%b, want 1", ifc.busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (ifc.busy !== 1'b0 || ifc.dout !== 16'h0 || ifc.rd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_reset: busy=%b dout=%h rv=%b, want 0 0000 0", ifc.busy, ifc.dout, ifc.rd_valid);
        end
        for (int i = 0; i < 16; i++) begin
            ifc.ce = 1'b1; ifc.wre = 1'b0; ifc.ad = 4'(i);
            exp = (i < 5) ? 16'h7FFF : 16'(16'h2000 + i);
            tick();
            vectors++;
            if (ifc.dout !== exp || ifc.rd_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL abort_read[%0d]: dout=%h rv=%b, want %h 1", i, ifc.dout, ifc.rd_valid, exp);
            end
        end
        ifc.ce = 1'b0;
        tick();
    endtask

    task automatic test_random();
        logic [7:0] model [64];
        logic [7:0] exp_dout;
        logic       exp_rv;
        for (int i = 0; i < 64; i++) begin
            ifr.ce = 1'b1; ifr.wre = 1'b1; ifr.ad = 6'(i); ifr.din = 8'(i * 7 + 3);
            model[i] = 8'(i * 7 + 3);
            tick();
        end
        ifr.ce = 1'b0;
        tick();
        exp_dout = 8'h00;
        for (int n = 0; n < 10000; n++) begin
            ifr.ce  = ($urandom_range(3) != 0);
            ifr.wre = 1'($urandom_range(1));
            ifr.ad  = 6'($urandom_range(63));
            ifr.din = 8'($urandom_range(255));
            exp_rv  = ifr.ce && !ifr.wre;
            if (exp_rv) exp_dout = model[ifr.ad];
            if (ifr.ce && ifr.wre) model[ifr.ad] = ifr.din;
            tick();
            vectors++;
            if (ifr.dout !== exp_dout || ifr.rd_valid !== exp_rv) begin
                miscompares++;
                $display("FAIL random[%0d]: dout=%h rv=%b, want %h %b", n, ifr.dout, ifr.rd_valid, exp_dout, exp_rv);
            end
        end
        ifr.ce = 1'b0;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset = 1'b1;
        if0.clr = 1'b0; if0.ce = 1'b0; if0.oce = 1'b0; if0.wre = 1'b0; if0.ad = '0; if0.din = '0;
        if1.clr = 1'b0; if1.ce = 1'b0; if1.oce = 1'b0; if1.wre = 1'b0; if1.ad = '0; if1.din = '0;
        ifc.clr = 1'b0; ifc.ce = 1'b0; ifc.oce = 1'b0; ifc.wre = 1'b0; ifc.ad = '0; ifc.din = '0;
        ifr.clr = 1'b0; ifr.ce = 1'b0; ifr.oce = 1'b0; ifr.wre = 1'b0; ifr.ad = '0; ifr.din = '0;
        test_reset();
        test_bypass();
        test_pipeline();
        test_write_modes();
        test_clear();
        test_clear_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sp_ram_param.md
# sp_ram_param

Parametrised single-port block RAM with a built-in memory-clear engine, the generalised successor to the fixed 4096x16 sample buffers in the OFDM datapath. Width, depth, output-register mode and write-collision mode are set by parameters. A clear request sweeps every address to a constant while user access is locked out. The block is the default buffer for FFT/IFFT working memory and symbol staging in the FPGA design.

## Interface
- DATA_W, 16, word width in bits (1..36)
- ADDR_W, 12, address width; DEPTH = 2**ADDR_W words
- READ_MODE, 0, 0 = bypass (one output register), 1 = pipeline (extra output register gated by oce)
- WRITE_MODE, 0, 0 = normal (dout holds on write), 1 = write-through (dout <= din), 2 = read-before-write (dout <= old mem[ad])
- CLR_VALUE, 0, DATA_W-bit word written to every address by the clear engine

- clk  in  1  sole clock; all logic on its rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- clr  in  1  single-cycle pulse; start memory clear
- busy  out  1  high while the clear sweep runs
- ce  in  1  user access enable
- oce  in  1  output-register enable (READ_MODE=1 only; ignored in READ_MODE=0)
- wre  in  1  1 = write, 0 = read (qualified by ce)
- ad  in  ADDR_W  user word address
- din  in  DATA_W  write data
- dout  out  DATA_W  read data
- rd_valid  out  1  one-cycle strobe: dout just loaded with read data

## Operation
- Reset: dout=0, rd_valid=0, busy=0, FSM=IDLE, clear counter=0, pipeline stage register and its valid=0. Array contents are not altered by reset.
- FSM states: IDLE, CLEAR.
- IDLE: clr=1 -> CLEAR, counter<=0; clr wins over a same-cycle user access (that access is dropped: no write, no dout update, no rd_valid).
- CLEAR: each cycle write CLR_VALUE to mem[counter], counter++; on the cycle counter==DEPTH-1 write then -> IDLE. clr while in CLEAR ignored.
- While busy: ce/wre/ad/din ignored, dout holds, rd_valid=0, pipeline stage holds.
- User read (IDLE, ce=1, wre=0): stage1 <= mem[ad]. READ_MODE=0: dout is stage1 itself. READ_MODE=1: dout <= stage1 on cycles with oce=1; stage1 data overwritten before an oce cycle is lost.
- User write (IDLE, ce=1, wre=1): mem[ad] <= din; stage1 per WRITE_MODE: 0 hold, 1 din, 2 previous mem[ad]. rd_valid never asserted for writes.
- ce=0: no array access, stage1 holds.
- Reset mid-sweep: sweep aborts, busy=0 next cycle, already-cleared words stay cleared, rest keep old data.

## Timing
- READ_MODE=0: read issued cycle N -> dout and rd_valid at N+1.
- READ_MODE=1: read issued N -> stage1 at N+1 -> dout and rd_valid at N+2 if oce=1 at edge N+2; rd_valid <= oce & stage1_valid, stage1_valid set by a read, cleared by oce or a non-read cycle.
- Back-to-back reads sustain one word per cycle in both modes.
- busy rises the cycle after clr, stays high exactly DEPTH cycles, falls the cycle after the last write; first user access accepted when busy=0.
- Write then read of same address on consecutive cycles returns the new data.

## Test plan
- Reset then write 0x1234 @ 0x005, 0xBEEF @ 0xFFF; read 0x005, 0xFFF back-to-back (READ_MODE=0) -> dout 0x1234 at N+1, 0xBEEF at N+2, rd_valid high both cycles.
- READ_MODE=1, oce=1: read 0x005 at N -> dout=0x1234, rd_valid=1 at N+2 only; repeat with oce=0 at N+2 -> dout holds, rd_valid=0.
- WRITE_MODE 0/1/2: mem[0x010]=0x00AA, write 0x0055 to 0x010 -> dout unchanged / 0x0055 / 0x00AA next cycle, rd_valid=0.
- ADDR_W=4, CLR_VALUE=0x7FFF: preload all words, pulse clr with simultaneous write -> write dropped, busy high 16 cycles, ce ignored meanwhile, all 16 reads return 0x7FFF.
- ADDR_W=4: clr, assert reset after 5 busy cycles -> busy=0 next cycle, dout=0, addresses 0..4 read CLR_VALUE, 5..15 keep preload.
- DATA_W=8, ADDR_W=6 random read/write sequence against scoreboard model -> zero mismatches over 10000 cycles.
